ldm_stm_sequencer: RTL and testbench

Block-transfer sequencer for ARM LDM/STM instructions. It sits between the decode stage and the 16-entry register file, and drives the register file's port-B address, write-enable and write-data lines. Given a 16-bit register list, a base value and an addressing mode, it walks the list lowest-register-first. For each listed register it issues one word memory transaction, then optionally writes the updated base back to Rn.

---
 rtl/ldm_stm_sequencer.sv | 178 +++++++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer: walks an LDM/STM register list lowest-first, issuing one
// word memory transaction per listed register, then optionally writes the
// updated base back to Rn through register-file port B.
module ldm_stm_sequencer (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic        is_load_in,
    input  logic        up_in,
    input  logic        pre_in,
    input  logic        writeback_in,
    input  logic [3:0]  base_reg_in,
    input  logic [31:0] base_val_in,
    input  logic [15:0] reg_list_in,
    input  logic [31:0] reg_rdata_in,
    input  logic [31:0] mem_rdata_in,
    input  logic        mem_ack_in,
    output logic [3:0]  reg_addr_out,
    output logic        reg_write_en_out,
    output logic [31:0] reg_wdata_out,
    output logic        mem_req_out,
    output logic        mem_we_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_wdata_out,
    output logic        busy_out,
    output logic        done_out
);

    typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_WRITE, S_WB, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] list_q;
    logic        is_load_q;
    logic        do_wb_q;
    logic [3:0]  base_reg_q;
    logic [31:0] addr_q;
    logic [31:0] final_base_q;
    logic [31:0] wdata_q;

    logic [4:0]  n_cnt;
    logic [31:0] span;
    logic [31:0] start_addr;
    logic [31:0] final_base;
    logic        start_wb;
    logic [3:0]  cur;
    logic [15:0] list_rest;
    logic        last;
    state_t      tail_state;

    // Popcount of the incoming list; 4n is the size of the transferred block.
    always_comb begin
        n_cnt = '0;
        for (int i = 0; i < 16; i++)
            n_cnt = n_cnt + {4'd0, reg_list_in[i]};
    end

    assign span = {25'd0, n_cnt, 2'b00};

    // Starting address and final base for the four addressing modes.
    always_comb begin
        case ({up_in, pre_in})
            2'b10:   start_addr = base_val_in;                      // IA
            2'b11:   start_addr = base_val_in + 32'd4;              // IB
            2'b00:   start_addr = base_val_in - span + 32'd4;       // DA
            default: start_addr = base_val_in - span;               // DB
        endcase
        final_base = up_in ? (base_val_in + span) : (base_val_in - span);
    end

    // A load that includes Rn keeps the loaded value, so writeback is dropped.
    assign start_wb = writeback_in && !(is_load_in && reg_list_in[base_reg_in]);

    // Lowest set bit of the remaining list is the register being transferred.
    always_comb begin
        cur = '0;
        for (int i = 15; i >= 0; i--)
            if (list_q[i]) cur = 4'(i);
    end

    assign list_rest  = list_q & ~(16'd1 << cur);
    assign last       = (list_rest == 16'd0);
    assign tail_state = do_wb_q ? S_WB : S_DONE;

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and port-B / memory output decode.
    always_comb begin
        state_d          = state_q;
        reg_addr_out     = '0;
        reg_write_en_out = 1'b0;
        mem_req_out      = 1'b0;
        mem_we_out       = 1'b0;
        mem_addr_out     = '0;
        mem_wdata_out    = '0;
        case (state_q)
            S_IDLE: begin
                if (start_in)
                    state_d = (reg_list_in == 16'd0) ? S_DONE : S_ACCESS;
            end
            S_ACCESS: begin
                reg_addr_out  = cur;
                mem_req_out   = 1'b1;
                mem_we_out    = !is_load_q;
                mem_addr_out  = {addr_q[31:2], 2'b00};
                mem_wdata_out = is_load_q ? 32'd0 : reg_rdata_in;
                if (mem_ack_in) begin
                    if (is_load_q) state_d = S_WRITE;
                    else           state_d = last ? tail_state : S_ACCESS;
                end
            end
            S_WRITE: begin
                reg_addr_out     = cur;
                reg_write_en_out = 1'b1;
                state_d          = last ? tail_state : S_ACCESS;
            end
            S_WB: begin
                reg_addr_out     = base_reg_q;
                reg_write_en_out = 1'b1;
                state_d          = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign reg_wdata_out = wdata_q;
    assign busy_out      = (state_q != S_IDLE);
    assign done_out      = (state_q == S_DONE);

    // Operation context: latched on start, list/address advanced per transfer.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            list_q       <= '0;
            is_load_q    <= 1'b0;
            do_wb_q      <= 1'b0;
            base_reg_q   <= '0;
            addr_q       <= '0;
            final_base_q <= '0;
            wdata_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_in) begin
                        list_q       <= reg_list_in;
                        is_load_q    <= is_load_in;
                        do_wb_q      <= start_wb;
                        base_reg_q   <= base_reg_in;
                        addr_q       <= start_addr;
                        final_base_q <= final_base;
                    end
                end
                S_ACCESS: begin
                    if (mem_ack_in) begin
                        if (is_load_q) begin
                            wdata_q <= mem_rdata_in;
                        end else begin
                            list_q <= list_rest;
                            addr_q <= addr_q + 32'd4;
                        end
                    end
                end
                S_WRITE: begin
                    list_q <= list_rest;
                    addr_q <= addr_q + 32'd4;
                end
                default: ;
            endcase
            // Write data for the base update is staged on entry to WB.
            if (state_d == S_WB && state_q != S_WB)
                wdata_q <= final_base_q;
        end
    end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer with a wait-state memory responder
// and a posedge transaction log of memory accesses and register writes.
module tb_ldm_stm_sequencer;

    logic        clk_in, rst_in, start_in, is_load_in, up_in, pre_in, writeback_in;
    logic [3:0]  base_reg_in;
    logic [31:0] base_val_in;
    logic [15:0] reg_list_in;
    logic [31:0] reg_rdata_in, mem_rdata_in;
    logic        mem_ack_in;
    logic [3:0]  reg_addr_out;
    logic        reg_write_en_out;
    logic [31:0] reg_wdata_out;
    logic        mem_req_out, mem_we_out;
    logic [31:0] mem_addr_out, mem_wdata_out;
    logic        busy_out, done_out;

    ldm_stm_sequencer dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
        .is_load_in(is_load_in), .up_in(up_in), .pre_in(pre_in),
        .writeback_in(writeback_in), .base_reg_in(base_reg_in),
        .base_val_in(base_val_in), .reg_list_in(reg_list_in),
        .reg_rdata_in(reg_rdata_in), .mem_rdata_in(mem_rdata_in),
        .mem_ack_in(mem_ack_in), .reg_addr_out(reg_addr_out),
        .reg_write_en_out(reg_write_en_out), .reg_wdata_out(reg_wdata_out),
        .mem_req_out(mem_req_out), .mem_we_out(mem_we_out),
        .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out),
        .busy_out(busy_out), .done_out(done_out)
    );

    typedef struct { logic [31:0] addr; logic we; logic [31:0] data; } mtx_t;
    typedef struct { logic [3:0] a; logic [31:0] d; } wtx_t;

    mtx_t        mem_log[$];
    wtx_t        wr_log[$];
    logic [31:0] ld_q[$];
    int          mem_waits;
    int          wcnt;
    int          stab_err, wait_seen;
    logic        pend;
    logic [31:0] p_addr, p_wd;
    int          n_vec, n_err;

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Register file: each register reads as 0x1000 + index.
    assign reg_rdata_in = 32'h1000 + {28'd0, reg_addr_out};

    // Memory responder: acks after mem_waits idle cycles, returns queued load data.
    always @(negedge clk_in) begin
        if (mem_req_out) begin
            if (wcnt >= mem_waits) begin
                mem_ack_in = 1'b1;
                wcnt = 0;
                if (!mem_we_out) mem_rdata_in = (ld_q.size() > 0) ? ld_q.pop_front() : 32'hDEAD_BEEF;
            end else begin
                mem_ack_in = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack_in = 1'b0;
            wcnt = 0;
        end
    end

    // Transaction log and request-stability monitor.
    always @(posedge clk_in) begin
        if (rst_in) begin
            pend = 1'b0;
        end else begin
            if (mem_req_out && mem_ack_in)
                mem_log.push_back('{addr: mem_addr_out, we: mem_we_out, data: mem_wdata_out});
            if (reg_write_en_out)
                wr_log.push_back('{a: reg_addr_out, d: reg_wdata_out});
            if (mem_req_out) begin
                if (pend && (mem_addr_out !== p_addr || mem_wdata_out !== p_wd)) stab_err++;
                if (!mem_ack_in) wait_seen++;
                pend   = !mem_ack_in;
                p_addr = mem_addr_out;
                p_wd   = mem_wdata_out;
            end else begin
                pend = 1'b0;
            end
        end
    end

    task automatic clear_logs();
        mem_log.delete();
        wr_log.delete();
        ld_q.delete();
        stab_err  = 0;
        wait_seen = 0;
    endtask

    // Starts one operation and waits for done_out; cyc = cycles from start edge
    // (-1 on timeout). poke_cyc re-asserts start_in with a full list mid-run.
    task automatic run_op(input logic ld, input logic up, input logic pre, input logic wb,
                          input logic [3:0] rn, input logic [31:0] base, input logic [15:0] list,
                          input int poke_cyc, output int cyc, output logic done_after,
                          output logic busy_ok);
        @(negedge clk_in);
        is_load_in = ld; up_in = up; pre_in = pre; writeback_in = wb;
        base_reg_in = rn; base_val_in = base; reg_list_in = list;
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        while (!done_out && cyc < 300) begin
            if (!busy_out) busy_ok = 1'b0;
            @(negedge clk_in);
            cyc++;
            start_in = (cyc == poke_cyc);
            if (cyc == poke_cyc) reg_list_in = 16'hFFFF;
        end
        start_in = 1'b0;
        if (!done_out) cyc = -1;
        if (!busy_out) busy_ok = 1'b0;
        @(negedge clk_in);
        done_after = done_out | busy_out;
    endtask

    task automatic test_reset();
        n_vec++;
        if ({reg_addr_out, reg_write_en_out, reg_wdata_out, mem_req_out, mem_we_out,
             mem_addr_out, mem_wdata_out, busy_out, done_out} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got addr=%h we=%b wd=%h req=%b mwe=%b ma=%h mwd=%h busy=%b done=%b want all 0",
                     reg_addr_out, reg_write_en_out, reg_wdata_out, mem_req_out, mem_we_out,
                     mem_addr_out, mem_wdata_out, busy_out, done_out);
        end
    endtask

    task automatic test_stmia();
        int cyc; logic da, bo;
        clear_logs(); mem_waits = 0;
        run_op(1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 32'h100, 16'h000B, -1, cyc, da, bo);
        n_vec++; if (cyc !== 5) begin n_err++; $display("FAIL stmia_latency: got %0d want 5", cyc); end
        n_vec++; if (mem_log.size() !== 3) begin n_err++; $display("FAIL stmia_count: got %0d want 3", mem_log.size()); end
        else begin
            n_vec++;
            if (mem_log[0].addr !== 32'h100 || mem_log[0].data !== 32'h1000 || mem_log[0].we !== 1'b1 ||
                mem_log[1].addr !== 32'h104 || mem_log[1].data !== 32'h1001 || mem_log[1].we !== 1'b1 ||
                mem_log[2].addr !== 32'h108 || mem_log[2].data !== 32'h1003 || mem_log[2].we !== 1'b1) begin
                n_err++;
                $display("FAIL stmia_stores: got %h/%h %h/%h %h/%h want 100/1000 104/1001 108/1003",
                         mem_log[0].addr, mem_log[0].data, mem_log[1].addr, mem_log[1].data,
                         mem_log[2].addr, mem_log[2].data);
            end
        end
        n_vec++; if (wr_log.size() !== 1) begin n_err++; $display("FAIL stmia_wb_count: got %0d want 1", wr_log.size()); end
        else begin
            n_vec++;
            if (wr_log[0].a !== 4'd5 || wr_log[0].d !== 32'h10C) begin
                n_err++; $display("FAIL stmia_wb: got r%0d=%h want r5=10c", wr_log[0].a, wr_log[0].d);
            end
        end
        n_vec++; if (bo !== 1'b1 || da !== 1'b0) begin n_err++; $display("FAIL stmia_busy_done: got busy_ok=%b after=%b want 1 0", bo, da); end
    endtask

    task automatic test_ldmdb();
        int cyc; logic da, bo;
        clear_logs(); mem_waits = 0;
        ld_q.push_back(32'hA); ld_q.push_back(32'hB);
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 4'd4, 32'h200, 16'h8001, -1, cyc, da, bo);
        n_vec++; if (cyc !== 6) begin n_err++; $display("FAIL ldmdb_latency: got %0d want 6", cyc); end
        n_vec++; if (mem_log.size() !== 2) begin n_err++; $display("FAIL ldmdb_count: got %0d want 2", mem_log.size()); end
        else begin
            n_vec++;
            if (mem_log[0].addr !== 32'h1F8 || mem_log[1].addr !== 32'h1FC ||
                mem_log[0].we !== 1'b0 || mem_log[1].we !== 1'b0) begin
                n_err++; $display("FAIL ldmdb_addr: got %h %h want 1f8 1fc loads", mem_log[0].addr, mem_log[1].addr);
            end
        end
        n_vec++; if (wr_log.size() !== 3) begin n_err++; $display("FAIL ldmdb_wr_count: got %0d want 3", wr_log.size()); end
        else begin
            n_vec++;
            if (wr_log[0].a !== 4'd0 || wr_log[0].d !== 32'hA || wr_log[1].a !== 4'd15 || wr_log[1].d !== 32'hB ||
                wr_log[2].a !== 4'd4 || wr_log[2].d !== 32'h1F8) begin
                n_err++;
                $display("FAIL ldmdb_writes: got r%0d=%h r%0d=%h r%0d=%h want r0=a r15=b r4=1f8",
                         wr_log[0].a, wr_log[0].d, wr_log[1].a, wr_log[1].d, wr_log[2].a, wr_log[2].d);
            end
        end
    endtask

    task automatic test_ldm_base_in_list();
        int cyc; logic da, bo;
        clear_logs(); mem_waits = 0;
        ld_q.push_back(32'h55);
        run_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 32'h400, 16'h0004, -1, cyc, da, bo);
        n_vec++; if (cyc !== 3) begin n_err++; $display("FAIL ldm_rn_latency: got %0d want 3", cyc); end
        n_vec++; if (wr_log.size() !== 1) begin n_err++; $display("FAIL ldm_rn_wr_count: got %0d want 1", wr_log.size()); end
        else begin
            n_vec++;
            if (wr_log[0].a !== 4'd2 || wr_log[0].d !== 32'h55) begin
                n_err++; $display("FAIL ldm_rn_value: got r%0d=%h want r2=55", wr_log[0].a, wr_log[0].d);
            end
        end
    endtask

    task automatic test_empty_list();
        int cyc; logic da, bo;
        clear_logs(); mem_waits = 0;
        run_op(1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 32'h800, 16'h0000, -1, cyc, da, bo);
        n_vec++; if (cyc !== 1) begin n_err++; $display("FAIL empty_latency: got %0d want 1", cyc); end
        n_vec++; if (mem_log.size() !== 0 || wr_log.size() !== 0) begin
            n_err++; $display("FAIL empty_activity: got mem=%0d wr=%0d want 0 0", mem_log.size(), wr_log.size());
        end
        n_vec++; if (da !== 1'b0) begin n_err++; $display("FAIL empty_done_pulse: got after=%b want 0", da); end
    endtask

    task automatic test_waits_and_busy_start();
        int cyc; logic da, bo;
        clear_logs(); mem_waits = 3;
        run_op(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 32'h300, 16'h0006, 3, cyc, da, bo);
        n_vec++; if (cyc !== 9) begin n_err++; $display("FAIL stmib_latency: got %0d want 9", cyc); end
        n_vec++; if (stab_err !== 0 || wait_seen !== 6) begin
            n_err++; $display("FAIL stmib_stable: got unstable=%0d waits=%0d want 0 6", stab_err, wait_seen);
        end
        repeat (5) @(negedge clk_in);
        n_vec++; if (mem_log.size() !== 2 || busy_out !== 1'b0) begin
            n_err++; $display("FAIL stmib_ignore_start: got stores=%0d busy=%b want 2 0", mem_log.size(), busy_out);
        end
        else begin
            n_vec++;
            if (mem_log[0].addr !== 32'h304 || mem_log[0].data !== 32'h1001 ||
                mem_log[1].addr !== 32'h308 || mem_log[1].data !== 32'h1002) begin
                n_err++; $display("FAIL stmib_stores: got %h/%h %h/%h want 304/1001 308/1002",
                                  mem_log[0].addr, mem_log[0].data, mem_log[1].addr, mem_log[1].data);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        int cyc, n; logic da, bo;
        clear_logs(); mem_waits = 2;
        ld_q.push_back(32'h11); ld_q.push_back(32'h22); ld_q.push_back(32'h33); ld_q.push_back(32'h44);
        @(negedge clk_in);
        is_load_in = 1'b1; up_in = 1'b1; pre_in = 1'b0; writeback_in = 1'b1;
        base_reg_in = 4'd9; base_val_in = 32'h500; reg_list_in = 16'h00F0;
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        n = 0;
        while (!(mem_log.size() == 1 && mem_req_out) && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        n_vec++; if (n >= 50) begin n_err++; $display("FAIL rst_mid_reach: got timeout want second access"); end
        #1 rst_in = 1'b1;
        #1;
        n_vec++;
        if ({reg_addr_out, reg_write_en_out, reg_wdata_out, mem_req_out, mem_we_out,
             mem_addr_out, mem_wdata_out, busy_out, done_out} !== '0) begin
            n_err++; $display("FAIL rst_mid_outputs: got req=%b we=%b busy=%b ma=%h wd=%h want all 0",
                              mem_req_out, reg_write_en_out, busy_out, mem_addr_out, reg_wdata_out);
        end
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        repeat (5) @(negedge clk_in);
        n_vec++; if (wr_log.size() !== 1 || mem_log.size() !== 1) begin
            n_err++; $display("FAIL rst_mid_quiet: got wr=%0d mem=%0d want 1 1", wr_log.size(), mem_log.size());
        end
        else begin
            n_vec++;
            if (wr_log[0].a !== 4'd4 || wr_log[0].d !== 32'h11) begin
                n_err++; $display("FAIL rst_mid_first: got r%0d=%h want r4=11", wr_log[0].a, wr_log[0].d);
            end
        end
        clear_logs(); mem_waits = 0;
        ld_q.push_back(32'h77); ld_q.push_back(32'h88);
        run_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd9, 32'h600, 16'h0003, -1, cyc, da, bo);
        n_vec++; if (cyc !== 6) begin n_err++; $display("FAIL rst_fresh_latency: got %0d want 6", cyc); end
        n_vec++; if (wr_log.size() !== 3) begin n_err++; $display("FAIL rst_fresh_count: got %0d want 3", wr_log.size()); end
        else begin
            n_vec++;
            if (wr_log[0].a !== 4'd0 || wr_log[0].d !== 32'h77 || wr_log[1].a !== 4'd1 || wr_log[1].d !== 32'h88 ||
                wr_log[2].a !== 4'd9 || wr_log[2].d !== 32'h608) begin
                n_err++;
                $display("FAIL rst_fresh_writes: got r%0d=%h r%0d=%h r%0d=%h want r0=77 r1=88 r9=608",
                         wr_log[0].a, wr_log[0].d, wr_log[1].a, wr_log[1].d, wr_log[2].a, wr_log[2].d);
            end
        end
        n_vec++; if (mem_log.size() !== 2) begin n_err++; $display("FAIL rst_fresh_mem: got %0d want 2", mem_log.size()); end
        else begin
            n_vec++;
            if (mem_log[0].addr !== 32'h600 || mem_log[1].addr !== 32'h604) begin
                n_err++; $display("FAIL rst_fresh_addr: got %h %h want 600 604", mem_log[0].addr, mem_log[1].addr);
            end
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_in = 1'b1; start_in = 1'b0; is_load_in = 1'b0; up_in = 1'b0; pre_in = 1'b0;
        writeback_in = 1'b0; base_reg_in = '0; base_val_in = '0; reg_list_in = '0;
        mem_rdata_in = '0; mem_ack_in = 1'b0; mem_waits = 0; wcnt = 0;
        pend = 1'b0; p_addr = '0; p_wd = '0; stab_err = 0; wait_seen = 0;
        #12;
        test_reset();
        @(negedge clk_in);
        rst_in = 1'b0;
        test_stmia();
        test_ldmdb();
        test_ldm_base_in_list();
        test_empty_list();
        test_waits_and_busy_start();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
